// File: rtl/uart_alu_interface.sv
`default_nettype none
// ============================================================================
// uart_alu_interface
// Collects operand A, operand B and an opcode from UART_RX, presents them to
// a combinational ALU and hands the latched result to UART_TX.
// Revision: 1.0
// ============================================================================
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_signal,
    output logic               o_busy,
    output logic               o_op_error,
    output logic               o_overrun
);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        COMPUTE = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       load_a;
    logic       load_b;
    logic       load_op;
    logic       load_tx;
    logic       op_reject;
    logic       op_valid;
    logic [NB_OP-1:0] op_code;

    assign op_code = i_rx_data[NB_OP-1:0];

    // The opcode byte must carry zeros above the opcode field to be accepted.
    always_comb begin
        op_valid = 1'b0;
        if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
            case (op_code)
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
                default:                        op_valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        load_tx    = 1'b0;
        op_reject  = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    load_a     = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    load_b     = 1'b1;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    if (op_valid) begin
                        load_op    = 1'b1;
                        state_next = COMPUTE;
                    end else begin
                        op_reject  = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                load_tx    = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase
    end

    assign o_busy = (state == COMPUTE) || (state == SEND) || (state == WAIT_TX);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_op    <= '0;
            o_tx_data   <= '0;
            o_tx_signal <= 1'b0;
            o_op_error  <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (load_a)  o_alu_a   <= i_rx_data;
            if (load_b)  o_alu_b   <= i_rx_data;
            if (load_op) o_alu_op  <= op_code;
            if (load_tx) o_tx_data <= i_alu_result;
            o_tx_signal <= load_tx;
            o_op_error  <= op_reject;
            // Bytes landing while a result is outstanding are dropped; remember it.
            if (i_rx_done && o_busy) o_overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Command sequencer that sits downstream of UART_RX and upstream of UART_TX.
- Collects three received bytes per transaction, in this order: operand A, operand B, opcode.
- Drives the combinational ALU operand and opcode lines, latches the ALU result, and hands it to UART_TX as one byte.
- Waits for UART_TX completion before it accepts the next transaction.

Parameters:
- NB_DATA, 8: width of the UART byte, the operands and the result.
- NB_OP, 6: width of the ALU opcode, taken from the opcode byte's low bits.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_done  in  1  one-cycle pulse from UART_RX (o_done_bit) when a byte is complete.
- i_rx_data  in  NB_DATA  received byte (UART_RX o_data_byte); valid while i_rx_done is high.
- i_tx_done  in  1  one-cycle pulse from UART_TX (o_done_bit) when the stop bit has been sent.
- i_alu_result  in  NB_DATA  combinational ALU result.
- o_alu_a  out  NB_DATA  operand A register.
- o_alu_b  out  NB_DATA  operand B register.
- o_alu_op  out  NB_OP  opcode register.
- o_tx_data  out  NB_DATA  byte to transmit (UART_TX i_data_byte).
- o_tx_signal  out  1  one-cycle transmit start pulse (UART_TX i_tx_signal).
- o_busy  out  1  high from entering COMPUTE until return to WAIT_A.
- o_op_error  out  1  one-cycle pulse when an invalid opcode byte is rejected.
- o_overrun  out  1  sticky flag: a byte arrived while busy; cleared only by reset.

Behaviour:
- Reset: asynchronous, all registers cleared. State WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0; o_tx_signal, o_busy, o_op_error, o_overrun = 0.
- Valid opcodes, compared on i_rx_data[NB_OP-1:0] with bits [7:NB_OP] required to be 0:
  - ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101
  - XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010
- FSM, all transitions on a rising edge of i_clock:
  - WAIT_A: on i_rx_done, o_alu_a <= i_rx_data; go to WAIT_B.
  - WAIT_B: on i_rx_done, o_alu_b <= i_rx_data; go to WAIT_OP.
  - WAIT_OP: on i_rx_done with a valid opcode, o_alu_op <= opcode; go to COMPUTE. With an invalid opcode: o_op_error pulses for 1 cycle; stay in WAIT_OP; operands are kept.
  - COMPUTE (1 cycle, ALU settles): o_tx_data <= i_alu_result; o_tx_signal <= 1; go to SEND.
  - SEND (1 cycle): o_tx_signal <= 0; go to WAIT_TX.
  - WAIT_TX: on i_tx_done, go to WAIT_A.
- Latency: op byte accepted at edge N -> o_alu_op valid after edge N. o_tx_data is loaded and o_tx_signal is high for exactly the cycle after edge N+1. o_tx_data holds until the next COMPUTE.
- o_busy = 1 in COMPUTE, SEND and WAIT_TX.
- A byte arriving in COMPUTE, SEND or WAIT_TX is discarded and o_overrun is set.
- i_tx_done outside WAIT_TX is ignored.
- i_rx_done and i_tx_done arriving in the same cycle in WAIT_TX: move to WAIT_A, discard the byte, set o_overrun.
- Operand registers are overwritten only in their own state; stale values persist between transactions.
- Reset asserted mid-transaction (any state): immediate return to reset values. A partially received transaction is lost, and any UART_TX transfer in flight is not tracked.
- No timeout between bytes.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 with ALU model = A+B -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'b100000; one o_tx_signal pulse with o_tx_data=0x08; after i_tx_done, state WAIT_A and o_busy=0.
- Bytes 0x0F, 0xF0, 0x3F (invalid), then 0x26 (XOR) -> o_op_error pulses once; o_tx_data=0xFF; o_overrun=0.
- Extra byte 0x55 injected while waiting for i_tx_done -> o_overrun=1 and stays 1; next transaction 0x02, 0x01, 0x22 (SUB) -> o_tx_data=0x01.
- Reset pulsed after operand B=0x07 is received -> all outputs 0; the next three bytes 0x01, 0x01, 0x20 produce o_tx_data=0x02.
- Full loop through BR_GENERATOR/UART_RX/UART_TX with 8'b10101010, 8'b00000001, SRL 0x02 -> serial line returns 8'b01010101.
